// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types and constants for the APB master bridge
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_bridge_state_e;

    // Wide enough for any DATA_WIDTH; users slice the low bits they need.
    localparam logic [1023:0] APB_TIMEOUT_RDATA = '0;

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core request/grant bus to single APB transactions
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] add_i,
    input  logic                  wen_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  r_opc_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    // A 1-bit counter is kept when the timeout is disabled so the width never collapses to zero.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_bridge_state_e   state;
    logic [CNT_W-1:0]    cnt;
    logic [ID_WIDTH-1:0] id_q;

    assign gnt_o = req_i && (state == IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            id_q      <= '0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            r_valid_o <= 1'b0;
            r_rdata_o <= '0;
            r_opc_o   <= 1'b0;
            r_id_o    <= '0;
        end else begin
            r_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        paddr_o   <= add_i;
                        pwrite_o  <= ~wen_i;
                        pwdata_o  <= wdata_i;
                        id_q      <= id_i;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    cnt       <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first so a completion in the last allowed cycle is not aborted.
                    if (pready_i) begin
                        r_rdata_o <= pwrite_o ? '0 : prdata_i;
                        r_opc_o   <= pslverr_i;
                        r_id_o    <= id_q;
                        r_valid_o <= 1'b1;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        state     <= IDLE;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
                        r_rdata_o <= APB_TIMEOUT_RDATA[DATA_WIDTH-1:0];
                        r_opc_o   <= 1'b1;
                        r_id_o    <= id_q;
                        r_valid_o <= 1'b1;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed vector bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i = 1'b0;
    logic [AW-1:0] add_i = '0;
    logic          wen_i = 1'b0;
    logic [DW-1:0] wdata_i = '0;
    logic [IW-1:0] id_i = '0;
    logic          gnt_o;
    logic          r_valid_o;
    logic [DW-1:0] r_rdata_o;
    logic          r_opc_o;
    logic [IW-1:0] r_id_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [DW-1:0] prdata_i = '0;
    logic          pready_i = 1'b0;
    logic          pslverr_i = 1'b0;

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .id_i(id_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .r_id_o(r_id_o), .psel_o(psel_o),
        .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string         name;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [IW-1:0] id;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_opc;
        int            exp_cyc;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that follows r_valid_o.
    task automatic run_vec(input vec_t v);
        bit seen = 0;
        int psel_cycles = 0;
        req_i = 1'b1; add_i = v.addr; wen_i = v.wen; wdata_i = v.wdata; id_i = v.id;
        prdata_i = v.prdata; pready_i = 1'b0; pslverr_i = 1'b0;
        @(negedge clk_i);
        check({v.name, " gnt"}, 32'(gnt_o), 32'd1);
        @(posedge clk_i); #1;
        req_i = 1'b0; add_i = ~v.addr; wdata_i = ~v.wdata; wen_i = ~v.wen;
        for (int cyc = 1; cyc < 40 && !seen; cyc++) begin
            pready_i  = (cyc >= 2) && ((cyc - 2) == v.waits);
            pslverr_i = pready_i & v.slverr;
            @(negedge clk_i);
            if (r_valid_o) begin
                seen = 1;
                check({v.name, " valid_cycle"}, 32'(cyc), 32'(v.exp_cyc));
                check({v.name, " rdata"}, r_rdata_o, v.exp_rdata);
                check({v.name, " opc"}, 32'(r_opc_o), 32'(v.exp_opc));
                check({v.name, " id"}, 32'(r_id_o), 32'(v.id));
                check({v.name, " psel_after"}, 32'({psel_o, penable_o}), 32'd0);
            end else if (psel_o) begin
                psel_cycles++;
                if (paddr_o !== v.addr || pwdata_o !== v.wdata || pwrite_o !== ~v.wen ||
                    penable_o !== (cyc >= 2))
                    check({v.name, " apb_stable"}, {paddr_o[15:0], pwdata_o[15:0]},
                          {v.addr[15:0], v.wdata[15:0]});
            end
            @(posedge clk_i); #1;
        end
        pready_i = 1'b0; pslverr_i = 1'b0;
        if (!seen) check({v.name, " no_response"}, 32'd0, 32'd1);
        check({v.name, " psel_cycles"}, 32'(psel_cycles), 32'(v.exp_cyc - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        logic [IW-1:0] next_id;

        //          name        wen   addr          wdata         id     waits prdata        err   exp_rdata     opc  cyc
        vecs[0] = '{"rd_zero",  1'b1, 32'h1A10_2004, 32'h0,       4'd3,  0,    32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 3};
        vecs[1] = '{"wr_wait",  1'b0, 32'h1A10_3000, 32'h1234_5678, 4'd5, 4,   32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 7};
        vecs[2] = '{"rd_err",   1'b1, 32'h1A10_2008, 32'h0,       4'd9,  1,    32'hBAD0_0001, 1'b1, 32'hBAD0_0001, 1'b1, 4};
        vecs[3] = '{"rd_tmo",   1'b1, 32'h1A10_200C, 32'h0,       4'hA,  20,   32'h0000_0055, 1'b0, 32'h0,        1'b1, 10};
        vecs[4] = '{"rd_last",  1'b1, 32'h1A10_2010, 32'h0,       4'hB,  7,    32'h0000_0777, 1'b0, 32'h0000_0777, 1'b0, 10};
        vecs[5] = '{"wr_err",   1'b0, 32'h1A10_3004, 32'hA5A5_5A5A, 4'hC, 2,   32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1, 5};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_outputs", {24'(r_rdata_o), r_id_o, r_valid_o, r_opc_o, psel_o, penable_o},
              32'd0);
        check("rst_apb", paddr_o | pwdata_o | 32'(pwrite_o) | 32'(gnt_o), 32'd0);
        rst_ni = 1'b1;
        req_i = 1'b1;
        #1;
        check("gnt_after_rst", 32'(gnt_o), 32'd1);
        req_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back: grants at 0,3,6 coincide with r_valid at 3,6; last valid at 9.
        pready_i = 1'b1; wen_i = 1'b1; prdata_i = 32'h0000_0042;
        req_i = 1'b1; next_id = 4'd1; id_i = next_id;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk_i);
            g = gnt_o;
            check($sformatf("b2b gnt c%0d", c), 32'(gnt_o), 32'(c == 0 || c == 3 || c == 6));
            check($sformatf("b2b valid c%0d", c), 32'(r_valid_o), 32'(c == 3 || c == 6 || c == 9));
            if (r_valid_o) check($sformatf("b2b id c%0d", c), 32'(r_id_o), 32'(c / 3));
            @(posedge clk_i); #1;
            if (g) begin
                next_id = next_id + 4'd1;
                id_i = next_id;
            end
            if (c == 6) req_i = 1'b0;
        end
        pready_i = 1'b0;

        // Reset during ACCESS
        req_i = 1'b1; wen_i = 1'b0; add_i = 32'h1A10_4000; wdata_i = 32'h0BAD_CAFE; id_i = 4'd7;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        @(posedge clk_i); #1;
        check("mid_rst access", 32'({psel_o, penable_o}), 32'd3);
        rst_ni = 1'b0;
        #1;
        check("mid_rst drop", 32'({psel_o, penable_o}), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check($sformatf("mid_rst no_valid c%0d", c), 32'({r_valid_o, psel_o}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
